// File: rtl/wbr_capture_shift_update.sv
// Wrapper boundary register for the s349 P1500 wrapper: the serial-unload/load end of the
// wrapper shift path.
//
// Captures the core functional outputs in parallel, shifts them out LSB-first on wso while
// loading fresh stimulus from wsi, and commits the loaded stimulus to the core test inputs on
// an update. Progress is tracked by a saturating shift counter and a one-cycle done pulse.
//
// Ports:
//   clk         wrapper clock, all state changes on posedge
//   WRSTN       asynchronous active-low reset
//   sel         SelectWR; strobes are ignored and all state holds while low
//   capture_wr  CaptureWR strobe (highest priority)
//   shift_wr    ShiftWR strobe
//   update_wr   UpdateWR strobe (lowest priority)
//   wsi         wrapper serial in, enters at shift_reg[WIDTH-1]
//   cfo         core functional outputs, captured in parallel
//   wso         wrapper serial out, combinational from shift_reg[0]
//   cti         core test inputs, driven from the update register
//   shift_cnt   shifts since the last capture, saturating at WIDTH
//   shift_done  one-cycle pulse after the shift that brings shift_cnt to WIDTH
//   state       last action: 0 idle (reset), 1 captured, 2 shifting, 3 updated
//
// WIDTH must lie in 2..32 and CW must satisfy 2**CW > WIDTH.

module wbr_capture_shift_update #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned CW    = 5
) (
  input  logic             clk,
  input  logic             WRSTN,
  input  logic             sel,
  input  logic             capture_wr,
  input  logic             shift_wr,
  input  logic             update_wr,
  input  logic             wsi,
  input  logic [WIDTH-1:0] cfo,
  output logic             wso,
  output logic [WIDTH-1:0] cti,
  output logic [CW-1:0]    shift_cnt,
  output logic             shift_done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StCaptured = 2'd1,
    StShifting = 2'd2,
    StUpdated  = 2'd3
  } state_e;

  // Resolved action for this cycle; at most one is performed.
  typedef enum logic [1:0] {
    ActNone,
    ActCapture,
    ActShift,
    ActUpdate
  } action_e;

  localparam logic [CW-1:0] CntMax  = CW'(WIDTH);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  action_e          action;
  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [WIDTH-1:0] update_reg_q, update_reg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  // Priority resolution: capture > shift > update. Losing strobes are dropped outright.
  always_comb begin
    action = ActNone;
    if (sel) begin
      if (capture_wr) begin
        action = ActCapture;
      end else if (shift_wr) begin
        action = ActShift;
      end else if (update_wr) begin
        action = ActUpdate;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge WRSTN) begin
    if (!WRSTN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the state simply records the last action performed.
  always_comb begin
    state_d = state_q;
    unique case (action)
      ActCapture: state_d = StCaptured;
      ActShift:   state_d = StShifting;
      ActUpdate:  state_d = StUpdated;
      default:    state_d = state_q;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    shift_reg_d  = shift_reg_q;
    update_reg_d = update_reg_q;
    cnt_d        = cnt_q;
    // The done pulse lasts one cycle regardless of what follows.
    done_d       = 1'b0;
    unique case (action)
      ActCapture: begin
        shift_reg_d = cfo;
        cnt_d       = '0;
      end
      ActShift: begin
        shift_reg_d = {wsi, shift_reg_q[WIDTH-1:1]};
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Only the WIDTH-1 -> WIDTH transition pulses; saturated shifts stay quiet.
        done_d = (cnt_q == CntLast);
      end
      ActUpdate: begin
        update_reg_d = shift_reg_q;
      end
      default: begin
        shift_reg_d = shift_reg_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge WRSTN) begin
    if (!WRSTN) begin
      shift_reg_q  <= '0;
      update_reg_q <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      shift_reg_q  <= shift_reg_d;
      update_reg_q <= update_reg_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
    end
  end

  // Outputs: all registered except wso, which exposes the current LSB before each shift edge.
  always_comb begin
    wso        = shift_reg_q[0];
    cti        = update_reg_q;
    shift_cnt  = cnt_q;
    shift_done = done_q;
    state      = state_q;
  end

endmodule

// File: tb/tb_wbr_capture_shift_update.sv
// Self-checking bench for wbr_capture_shift_update. Two instances (WIDTH=3 and WIDTH=11) share
// the control strobes, wsi and reset; each has its own cfo. A behavioural model of the
// boundary register tracks both chains as plain integers.

module tb_wbr_capture_shift_update;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        WRSTN, sel, capture_wr, shift_wr, update_wr, wsi;
  logic [2:0]  cfo_a;
  logic [10:0] cfo_b;

  logic        wso_a, done_a;
  logic [2:0]  cti_a;
  logic [1:0]  cnt_a, state_a;
  logic        wso_b, done_b;
  logic [10:0] cti_b;
  logic [4:0]  cnt_b;
  logic [1:0]  state_b;

  wbr_capture_shift_update #(.WIDTH(3), .CW(2)) u_dut_a (
    .clk        (clk),
    .WRSTN      (WRSTN),
    .sel        (sel),
    .capture_wr (capture_wr),
    .shift_wr   (shift_wr),
    .update_wr  (update_wr),
    .wsi        (wsi),
    .cfo        (cfo_a),
    .wso        (wso_a),
    .cti        (cti_a),
    .shift_cnt  (cnt_a),
    .shift_done (done_a),
    .state      (state_a)
  );

  wbr_capture_shift_update #(.WIDTH(11), .CW(5)) u_dut_b (
    .clk        (clk),
    .WRSTN      (WRSTN),
    .sel        (sel),
    .capture_wr (capture_wr),
    .shift_wr   (shift_wr),
    .update_wr  (update_wr),
    .wsi        (wsi),
    .cfo        (cfo_b),
    .wso        (wso_b),
    .cti        (cti_b),
    .shift_cnt  (cnt_b),
    .shift_done (done_b),
    .state      (state_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 is the 3-bit chain, index 1 the 11-bit chain.
  int unsigned m_w[2] = '{3, 11};
  int unsigned m_reg[2];
  int unsigned m_cti[2];
  int unsigned m_cnt[2];
  int unsigned m_done[2];
  int unsigned m_state[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_reg[i] = 0; m_cti[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_state[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 2; i++) begin
      int unsigned cfo_v;
      cfo_v = (i == 0) ? 32'(cfo_a) : 32'(cfo_b);
      m_done[i] = 0;
      if (sel) begin
        if (capture_wr) begin
          m_reg[i] = cfo_v;
          m_cnt[i] = 0;
          m_state[i] = 1;
        end else if (shift_wr) begin
          m_reg[i] = (m_reg[i] >> 1) | (32'(wsi) << (m_w[i] - 1));
          if (m_cnt[i] == m_w[i] - 1) m_done[i] = 1;
          if (m_cnt[i] < m_w[i]) m_cnt[i] = m_cnt[i] + 1;
          m_state[i] = 2;
        end else if (update_wr) begin
          m_cti[i] = m_reg[i];
          m_state[i] = 3;
        end
      end
    end
  endfunction

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_wso3"},   32'(wso_a),   m_reg[0] & 1);
    check({tag, "_cti3"},   32'(cti_a),   m_cti[0]);
    check({tag, "_cnt3"},   32'(cnt_a),   m_cnt[0]);
    check({tag, "_done3"},  32'(done_a),  m_done[0]);
    check({tag, "_state3"}, 32'(state_a), m_state[0]);
    check({tag, "_wso11"},  32'(wso_b),   m_reg[1] & 1);
    check({tag, "_cti11"},  32'(cti_b),   m_cti[1]);
    check({tag, "_cnt11"},  32'(cnt_b),   m_cnt[1]);
    check({tag, "_done11"}, 32'(done_b),  m_done[1]);
    check({tag, "_state11"}, 32'(state_b), m_state[1]);
  endtask

  task automatic drive(input logic s, input logic c, input logic sh, input logic u,
                       input logic d, input logic [2:0] fa, input logic [10:0] fb);
    sel = s; capture_wr = c; shift_wr = sh; update_wr = u; wsi = d; cfo_a = fa; cfo_b = fb;
  endtask

  // One clock: inputs already applied, sample 1 time unit after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    if (WRSTN) model_edge();
    else model_reset();
    check_all(tag);
  endtask

  initial begin
    WRSTN = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 11'd0);
    model_reset();

    // Reset with random strobes.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 11'($urandom));
      step("rst");
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 11'd0);
    WRSTN = 1'b1;
    step("rel");

    // Round trip on the 3-bit chain.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 11'h5A5);
    step("cap");
    check("cap_wso3_lit", 32'(wso_a), 1);
    check("cap_state_lit", 32'(state_a), 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 11'h0);
    step("sh1");
    check("sh1_wso3_lit", 32'(wso_a), 0);
    step("sh2");
    check("sh2_wso3_lit", 32'(wso_a), 1);
    wsi = 1'b0;
    step("sh3");
    check("sh3_done_lit", 32'(done_a), 1);
    check("sh3_cnt_lit", 32'(cnt_a), 3);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 11'h0);
    step("upd");
    check("upd_cti3_lit", 32'(cti_a), 3'b011);
    check("upd_done_lit", 32'(done_a), 0);
    check("upd_state_lit", 32'(state_a), 3);

    // sel=0: every strobe ignored.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 11'h7FF);
    step("nsel_c");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 11'h7FF);
    step("nsel_s");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 11'h7FF);
    step("nsel_u");
    check("nsel_cti3_lit", 32'(cti_a), 3'b011);

    // Simultaneous strobes.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b110, 11'h123);
    step("all3");
    check("all3_cti3_lit", 32'(cti_a), 3'b011);
    check("all3_state_lit", 32'(state_a), 1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 11'h0);
    step("shupd");
    check("shupd_state_lit", 32'(state_a), 2);
    check("shupd_cti3_lit", 32'(cti_a), 3'b011);

    // Saturation: capture then five shifts.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 11'h5A5);
    step("sat_cap");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 11'h0);
    for (int i = 0; i < 5; i++) begin
      wsi = 1'($urandom);
      step("sat_sh");
    end
    check("sat_cnt_lit", 32'(cnt_a), 3);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 11'h0);
    step("sat_idle");

    // 11-bit chain: capture, shift 4, update, then async reset mid-cycle.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 11'h5A5);
    step("b_cap");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 11'h0);
    for (int i = 0; i < 4; i++) step("b_sh");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 11'h0);
    step("b_upd");
    check("b_upd_cti_lit", 32'(cti_b), 11'h05A);
    #2 WRSTN = 1'b0;
    #1 model_reset();
    check_all("arst");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 11'h0);
    step("arst_hold");
    #2 WRSTN = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 11'h3C3);
    step("post_cap");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 5) == 0), 1'($urandom),
            ($urandom_range(0, 3) == 0), 1'($urandom), 3'($urandom), 11'($urandom));
      WRSTN = ($urandom_range(0, 49) != 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wbr_capture_shift_update.md
Name: wbr_capture_shift_update

Overview:
- Wrapper boundary register (WBR) for the s349 P1500 wrapper, forming the serial-unload/load end of the wrapper shift path.
- Captures the core's functional outputs in parallel and shifts them out serially on wso while loading new stimulus from wsi.
- Commits the loaded stimulus to the core test inputs on an update.
- Sequenced by WSP-style control strobes; tracks shift progress with a counter and a completion pulse.

Parameters:
- WIDTH, 11, number of boundary cells (chain length); legal range 2..32.
- CW, 5, width of shift counter; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  wrapper clock; all state changes on posedge.
- WRSTN  input  1  asynchronous active-low reset.
- sel  input  1  SelectWR; when 0 all strobes ignored, state holds.
- capture_wr  input  1  CaptureWR strobe.
- shift_wr  input  1  ShiftWR strobe.
- update_wr  input  1  UpdateWR strobe.
- wsi  input  1  wrapper serial in.
- cfo  input  WIDTH  core functional outputs to capture.
- wso  output  1  wrapper serial out = shift_reg[0].
- cti  output  WIDTH  core test inputs = update register.
- shift_cnt  output  CW  shifts since last capture, saturating at WIDTH.
- shift_done  output  1  one-cycle pulse when shift_cnt reaches WIDTH.
- state  output  2  FSM state encoding.

Behaviour:
- Reset (WRSTN=0, async): shift_reg=0, cti=0, shift_cnt=0, shift_done=0, state=IDLE(2'd0); wso=0 as a result.
- Release is synchronous in effect: first action on the first posedge with WRSTN=1.
- Strobe qualification: an action occurs only when sel=1.
- Priority when several strobes are high in one cycle: capture > shift > update; lower-priority strobes are dropped, not deferred.
- Capture: shift_reg<=cfo; shift_cnt<=0; state<=CAPTURED(2'd1).
- Shift: shift_reg<={wsi, shift_reg[WIDTH-1:1]} (LSB exits first).
  - shift_cnt increments, saturating at WIDTH.
  - state<=SHIFTING(2'd2).
- wso is combinational from shift_reg[0]: it presents the current bit before each shift edge. Zero clock latency from register to pin; one clock from wsi to shift_reg[WIDTH-1].
- shift_done: asserted for exactly the one cycle following the shift edge that moves shift_cnt from WIDTH-1 to WIDTH. Further saturated shifts do not re-pulse it.
- Update: cti<=shift_reg; state<=UPDATED(2'd3). shift_reg and shift_cnt are unchanged.
- Updating before shift_cnt reaches WIDTH is legal; it commits the partially shifted contents.
- cti changes only on update or reset; it is held stable during capture and shift.
- FSM states:
  - IDLE: reset only.
  - CAPTURED, SHIFTING, UPDATED: as above.
  - No strobe, or sel=0: state and all registers hold.
  - Any state may take any action; state reflects the last action performed.
- Reset mid-operation: immediate return to reset values, including cti. A partially shifted chain is discarded.
- shift_cnt upper bits beyond the WIDTH range are never reached; the saturation compare is equality with WIDTH.

Test Plan:
- Reset: drive strobes/wsi random with WRSTN=0 -> wso=0, cti=0, shift_cnt=0, shift_done=0, state=0. Assert WRSTN=0 asynchronously mid-cycle -> outputs clear before the next edge.
- Full round trip (WIDTH=3):
  - capture cfo=3'b101 -> state=1, wso=1.
  - Three shifts with wsi=1,1,0 -> wso samples 1,0,1; shift_reg=3'b011; shift_cnt=3; shift_done high one cycle after the third shift; state=2.
  - update -> cti=3'b011, state=3.
- sel=0 (WIDTH=3): pulse capture/shift/update with cfo=3'b111 -> no register, count, or state change. cti remains at its prior value.
- Simultaneous strobes (WIDTH=3), sel=1:
  - capture+shift+update in one cycle with cfo=3'b110 -> shift_reg=3'b110, shift_cnt=0, cti unchanged, state=1.
  - shift+update in one cycle -> shift only.
- Saturation (WIDTH=3): capture, then five shifts -> shift_cnt sequence 1,2,3,3,3; shift_done pulses exactly once.
- Reset mid-shift (WIDTH=11): capture 11'h5A5, shift 4 bits, then update -> cti=shifted value. Pulse WRSTN low -> cti=0, shift_cnt=0, state=0; next capture behaves normally.
